// File: rtl/dbgu_host.sv
// dbgu_host: turns memory read/write requests into a UART debug command byte stream
module dbgu_host #(
  parameter int RESP_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        busy
);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SET_CMD, SET_ADDR, OP_CMD, WR_DATA, RD_WAIT, DONE} state_t;
  state_t state;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] addr_nx, wdata_nx;
  // byte that follows the one currently on tx_data within a 4-byte field
  assign addr_nx  = 8'(addr_q >> {bcnt + 2'd1, 3'b000});
  assign wdata_nx = 8'(wdata_q >> {bcnt + 2'd1, 3'b000});
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 32'h0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      bcnt        <= 2'd0;
      tcnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          we_q        <= req_we;
          addr_q      <= req_addr;
          wdata_q     <= req_wdata;
          state       <= SET_CMD;
          req_ready   <= 1'b0;
          busy        <= 1'b1;
          tx_valid    <= 1'b1;
          tx_data     <= 8'h01;
          rsp_timeout <= 1'b0;
        end
        SET_CMD: if (tx_ready) begin
          state   <= SET_ADDR;
          bcnt    <= 2'd0;
          tx_data <= addr_q[7:0];
        end
        SET_ADDR: if (tx_ready) begin
          bcnt    <= bcnt + 2'd1;
          state   <= bcnt == 2'd3 ? OP_CMD : SET_ADDR;
          tx_data <= bcnt == 2'd3 ? (we_q ? 8'h04 : 8'h05) : addr_nx;
        end
        OP_CMD: if (tx_ready) begin
          state    <= we_q ? WR_DATA : RD_WAIT;
          tx_valid <= we_q;
          tx_data  <= we_q ? wdata_q[7:0] : 8'h00;
          tcnt     <= '0;
        end
        WR_DATA: if (tx_ready) begin
          bcnt      <= bcnt + 2'd1;
          state     <= bcnt == 2'd3 ? DONE : WR_DATA;
          tx_valid  <= bcnt != 2'd3;
          tx_data   <= bcnt == 2'd3 ? 8'h00 : wdata_nx;
          rsp_valid <= bcnt == 2'd3;
        end
        RD_WAIT: if (rx_valid) begin
          rsp_rdata[{bcnt, 3'b000} +: 8] <= rx_data;
          bcnt      <= bcnt + 2'd1;
          tcnt      <= '0;
          state     <= bcnt == 2'd3 ? DONE : RD_WAIT;
          rsp_valid <= bcnt == 2'd3;
        end else if (tcnt == TW'(RESP_TIMEOUT - 1)) begin
          state       <= DONE;
          rsp_valid   <= 1'b1;
          rsp_timeout <= 1'b1;
          rsp_rdata   <= '1;
          bcnt        <= 2'd0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        DONE: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbgu_host.sv
// tb_dbgu_host: randomized scoreboard bench for dbgu_host against a byte-stream protocol model
module tb_dbgu_host;
  localparam int TO = 100;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, tx_ready = 1, rx_valid = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [7:0] rx_data = 0;
  logic req_ready, rsp_valid, rsp_timeout, tx_valid, busy;
  logic [31:0] rsp_rdata;
  logic [7:0] tx_data;
  typedef struct {logic [31:0] rdata; logic to;} rsp_t;
  logic [7:0] exp_tx[$];
  rsp_t exp_rsp[$];
  int checks = 0, failures = 0, tx_count = 0, stall_mode = 0;
  logic [31:0] model_rdata = 0;

  dbgu_host #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // transmitter back-pressure: always ready, or random stalls up to 50 cycles
  initial forever begin
    int n;
    if (stall_mode == 0) begin
      @(negedge clk);
      tx_ready = 1;
    end else begin
      n = ($urandom % 3 == 0) ? $urandom_range(0, 50) : $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        tx_ready = 0;
      end
      @(negedge clk);
      tx_ready = 1;
    end
  end

  // monitor: samples just before each rising edge and pops the scoreboard
  initial begin
    logic hold_p, prev_rv, mon_to;
    logic [7:0] hold_b;
    logic [31:0] mon_rdata;
    rsp_t r;
    hold_p = 0; prev_rv = 0; mon_to = 0; hold_b = 0; mon_rdata = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        hold_p = 0; prev_rv = 0; mon_rdata = 0; mon_to = 0;
      end else begin
        if (hold_p) begin
          chk("tx_valid_held", tx_valid, 1);
          chk("tx_data_held", tx_data, hold_b);
        end
        hold_p = tx_valid && !tx_ready;
        hold_b = tx_data;
        if (tx_valid && tx_ready) begin
          tx_count++;
          if (exp_tx.size() == 0) chk("tx_unexpected", tx_data, 32'hxx);
          else chk("tx_byte", tx_data, exp_tx.pop_front());
        end
        chk("busy_vs_ready", busy, !req_ready);
        if (rsp_valid) begin
          chk("rsp_one_cycle", prev_rv, 0);
          if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_timeout", rsp_timeout, r.to);
            chk("rsp_no_tx", tx_valid, 0);
            mon_rdata = r.rdata;
            mon_to = r.to;
          end
        end else if (req_ready) begin
          chk("rdata_stable", rsp_rdata, mon_rdata);
          chk("timeout_stable", rsp_timeout, mon_to);
        end
        prev_rv = rsp_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", req_ready, 1);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_tx.push_back(8'h01); push_word(a); exp_tx.push_back(8'h04); push_word(d);
    exp_rsp.push_back('{model_rdata, 1'b0});
    issue(1, a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int nb);
    int n;
    exp_tx.push_back(8'h01); push_word(a); exp_tx.push_back(8'h05);
    model_rdata = (nb == 4) ? d : 32'hFFFF_FFFF;
    exp_rsp.push_back('{model_rdata, nb != 4});
    issue(0, a, 0);
    n = 0;
    // stray strobes until the response window opens; these must be ignored
    while (!(busy && !tx_valid) && n < 5000) begin
      rx_valid = ($urandom % 4 == 0);
      rx_data = $urandom;
      @(negedge clk);
      n++;
    end
    rx_valid = 0;
    chk("rd_wait_reached", busy && !tx_valid, 1);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rx_valid = 1;
      rx_data = d[8*i +: 8];
      @(negedge clk);
      rx_valid = 0;
    end
    if (nb < 4) begin
      n = 0;
      while (!rsp_valid && n < 3 * TO) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", n, TO);
    end
  endtask

  initial begin
    int base, n;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    do_write(32'h0000_0020, 32'hAABB_CCDD);
    do_read(32'h0000_0020, 32'hAABB_CCDD, 4);
    stall_mode = 1;
    do_write(32'h0000_0020, 32'hAABB_CCDD);
    do_read(32'h0000_0020, 32'h1234_5678, 4);
    stall_mode = 0;
    do_read(32'h0000_0040, 32'h5566_7788, 2);

    // reset while the third address byte is on the wire
    wait_idle();
    base = tx_count;
    do_write(32'h1122_3344, 32'hDEAD_BEEF);
    n = 0;
    while (tx_count < base + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reset_point_reached", tx_count, base + 3);
    rst = 1;
    exp_tx.delete();
    exp_rsp.delete();
    model_rdata = 0;
    @(negedge clk);
    rst = 0;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_timeout", rsp_timeout, 0);
    chk("arst_rsp_rdata", rsp_rdata, 0);
    for (int i = 0; i < 6; i++) begin
      rx_valid = i[0];
      rx_data = $urandom;
      @(negedge clk);
    end
    rx_valid = 0;
    do_read(32'h0000_0020, 32'hCAFE_F00D, 4);

    for (int t = 0; t < 14; t++) begin
      stall_mode = $urandom % 2;
      if ($urandom % 2) do_write($urandom, $urandom);
      else do_read($urandom, $urandom, ($urandom % 5 == 0) ? 2 : 4);
    end

    stall_mode = 0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbgu_host.md
DBGU_HOST -- requirements
Module: dbgu_host

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 65535, meaning max idle cycles allowed between response bytes of a read.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  host request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we  input  1  1 = memory write, 0 = memory read.
REQ-007 SHALL have port req_addr  input  32  target address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_timeout  output  1  qualifies rsp_valid: read aborted on timeout.
REQ-012 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data valid.
REQ-014 SHALL have port tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready.
REQ-015 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-016 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, SET_CMD, SET_ADDR, OP_CMD, WR_DATA, RD_WAIT, DONE.
REQ-019 SHALL assert req_ready only in IDLE; on acceptance latch req_we/addr/wdata and go to SET_CMD.
REQ-020 SHALL in SET_CMD present tx_data=0x01; on transfer go to SET_ADDR with byte counter cleared.
REQ-021 SHALL in SET_ADDR send latched address as 4 bytes, least significant first (0x00000020 -> 20 00 00 00); after 4th transfer go to OP_CMD.
REQ-022 SHALL in OP_CMD present 0x04 if write, 0x05 if read; on transfer go to WR_DATA (write) or RD_WAIT (read).
REQ-023 SHALL in WR_DATA send latched wdata as 4 bytes LSB first; after 4th transfer go to DONE with rsp_timeout=0.
REQ-024 SHALL hold tx_data stable and tx_valid high from first presentation until transfer; tx_valid low in IDLE, RD_WAIT, DONE.
REQ-025 SHALL in RD_WAIT shift each rx_valid byte into rsp_rdata LSB-first (byte n -> bits 8n+7:8n); after 4th byte go to DONE with rsp_timeout=0.
REQ-026 SHALL ignore rx_valid in every state other than RD_WAIT, including a strobe coincident with the OP_CMD transfer.
REQ-027 SHALL count cycles in RD_WAIT, clearing on entry and on each rx byte; when count reaches RESP_TIMEOUT go to DONE with rsp_timeout=1 and rsp_rdata=0xFFFFFFFF.
REQ-028 SHALL in DONE pulse rsp_valid for exactly one cycle and return to IDLE next cycle; earliest next acceptance is the cycle after DONE.
REQ-029 SHALL keep rsp_rdata/rsp_timeout stable from DONE until the next request is accepted; writes leave rsp_rdata unchanged.
REQ-030 SHALL tolerate tx_ready stalls of any length in any sending state with no byte lost, duplicated or reordered.
REQ-031 SHALL use a 2-bit byte counter wrapping 3->0 at each 4-byte field end and a timeout counter of width clog2(RESP_TIMEOUT+1).

Reset
REQ-032 SHALL on rst, in any state including mid-transfer, next cycle be in IDLE with req_ready=1, busy=0, tx_valid=0, tx_data=0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, counters 0.
REQ-033 SHALL not issue rsp_valid for a request aborted by rst.

Verification
REQ-034 SHALL pass: write addr 0x00000020 data 0xAABBCCDD, tx_ready=1 -> tx bytes 01 20 00 00 00 04 DD CC BB AA, then one rsp_valid pulse, rsp_timeout=0.
REQ-035 SHALL pass: read addr 0x00000020, rx bytes DD CC BB AA after 0x05 sent -> rsp_valid with rsp_rdata=0xAABBCCDD, rsp_timeout=0.
REQ-036 SHALL pass: write with tx_ready toggled pseudo-randomly (stalls up to 50 cycles) -> identical 10-byte sequence, tx_data never changes while tx_valid && !tx_ready.
REQ-037 SHALL pass: read with RESP_TIMEOUT=100, only 2 rx bytes sent -> rsp_valid, rsp_timeout=1, rsp_rdata=0xFFFFFFFF, 100 cycles after 2nd byte.
REQ-038 SHALL pass: rst asserted during SET_ADDR byte 2, stray rx_valid strobes in IDLE -> IDLE next cycle, no rsp_valid, following read returns correct data.
